// File: rtl/eight_queen_pkg.sv
// Shared types for the 8-queen controller: FSM state encoding and board geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eight_queen_pkg;

    localparam int N_QUEENS = 8;
    localparam int ROW_W    = $clog2(N_QUEENS);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        ENTRY,
        CHECK,
        CONFLICT,
        BACKTRACK,
        SOLVED,
        EMIT,
        DONE,
        FAIL
    } state_t;

    // States in which the backtracking search is actively working on the board.
    function automatic logic is_search_state(input state_t s);
        return (s == ENTRY) || (s == CHECK) || (s == CONFLICT) || (s == BACKTRACK);
    endfunction

endpackage

// File: rtl/eight_queen_controller.sv
// Sequencer for the 8-queen datapath: backtracking search over rows 0..7, then streams the board row by row.
// Latency: strobes are Mealy (same cycle as state/status); state and row mirror update on the next clk edge.
// Backpressure: in EMIT, out_valid and the selected row are held while out_ready=0; the row only advances on out_ready.
// Optional build macro SEARCH_CYCLE_COUNT_EN adds a saturating search-cycle counter on search_cycles.
module eight_queen_controller
    import eight_queen_pkg::*;
#(
    parameter int CYCLE_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROW_W-1:0]       out_row,
    output logic                   enable_output,
    output logic                   shift_right,
    output logic                   counter_reset,
    output logic                   count_up,
    output logic                   count_down,
    output logic                   count,
    output logic                   load_counter,
    input  logic                   cout,
    input  logic                   down_counter_zero,
    input  logic                   last_queen_counter_zero,
    input  logic                   last_cell,
    input  logic                   safe,
    output logic [CYCLE_CNT_W-1:0] search_cycles
);

    state_t           state_q, state_d;
    // Local copy of the datapath row counter, needed to label each emitted row.
    logic [ROW_W-1:0] row_q, row_d;

    // State register and row mirror; a low reset aborts any search back to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Next-state, datapath strobes and handshake outputs.
    always_comb begin
        state_d       = state_q;
        enable_output = 1'b0;
        shift_right   = 1'b0;
        counter_reset = 1'b0;
        count_up      = 1'b0;
        count_down    = 1'b0;
        count         = 1'b0;
        load_counter  = 1'b0;
        out_valid     = 1'b0;
        out_row       = '0;
        done          = 1'b0;
        fail          = 1'b0;
        busy          = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = INIT;
            end
            INIT: begin
                counter_reset = 1'b1;
                state_d       = ENTRY;
            end
            ENTRY: begin
                if (cout) begin
                    state_d = SOLVED;
                end else if (last_queen_counter_zero) begin
                    // Nothing above row 0 can attack it, so place it without checking.
                    count_up = 1'b1;
                end else begin
                    load_counter = 1'b1;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (!safe) begin
                    state_d = CONFLICT;
                end else if (down_counter_zero) begin
                    count_up = 1'b1;
                    state_d  = ENTRY;
                end else begin
                    count = 1'b1;
                end
            end
            CONFLICT: begin
                if (!last_cell) begin
                    shift_right = 1'b1;
                    state_d     = ENTRY;
                end else if (last_queen_counter_zero) begin
                    state_d = FAIL;
                end else begin
                    // Wrap this row back to column 0 and retreat one row.
                    shift_right = 1'b1;
                    count_down  = 1'b1;
                    state_d     = BACKTRACK;
                end
            end
            BACKTRACK: begin
                if (last_cell && last_queen_counter_zero) begin
                    state_d = FAIL;
                end else if (last_cell) begin
                    shift_right = 1'b1;
                    count_down  = 1'b1;
                end else begin
                    shift_right = 1'b1;
                    state_d     = ENTRY;
                end
            end
            SOLVED: begin
                counter_reset = 1'b1;
                state_d       = EMIT;
            end
            EMIT: begin
                if (cout) begin
                    state_d = DONE;
                end else begin
                    enable_output = 1'b1;
                    out_valid     = 1'b1;
                    out_row       = row_q;
                    count_up      = out_ready;
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            FAIL: begin
                busy = 1'b0;
                fail = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase

        row_d = row_q;
        if (counter_reset)   row_d = '0;
        else if (count_up)   row_d = row_q + ROW_W'(1);
        else if (count_down) row_d = row_q - ROW_W'(1);
    end

`ifdef SEARCH_CYCLE_COUNT_EN
    logic [CYCLE_CNT_W-1:0] cyc_q, cyc_d;

    // Search-cycle counter: cleared when a search starts, saturates, frozen outside the search.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == INIT) begin
            cyc_d = '0;
        end else if (is_search_state(state_q) && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYCLE_CNT_W'(1);
        end
    end

    // Search-cycle counter register.
    always_ff @(posedge clk) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign search_cycles = cyc_q;
`else
    assign search_cycles = '0;
`endif

endmodule

// File: tb/tb_eight_queen_controller.sv
// Bench for eight_queen_controller with a behavioural 8-queen datapath and a stub status mode.
// Latency: n/a.
// Backpressure: out_ready is stalled for three cycles on row 3 in one run.
module tb_eight_queen_controller;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic          busy, done, fail, out_valid;
    logic [2:0]    out_row;
    logic          enable_output, shift_right, counter_reset, count_up, count_down, count, load_counter;
    logic          cout, down_counter_zero, last_queen_counter_zero, last_cell, safe;
    logic [CW-1:0] search_cycles;

    always #5 clk = ~clk;

    eight_queen_controller #(.CYCLE_CNT_W(CW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .busy                    (busy),
        .done                    (done),
        .fail                    (fail),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_row                 (out_row),
        .enable_output           (enable_output),
        .shift_right             (shift_right),
        .counter_reset           (counter_reset),
        .count_up                (count_up),
        .count_down              (count_down),
        .count                   (count),
        .load_counter            (load_counter),
        .cout                    (cout),
        .down_counter_zero       (down_counter_zero),
        .last_queen_counter_zero (last_queen_counter_zero),
        .last_cell               (last_cell),
        .safe                    (safe),
        .search_cycles           (search_cycles)
    );

    // ---------------- behavioural datapath ----------------
    logic [7:0] board [8];
    int         r, j;
    logic       stub_mode, stub_row0;
    logic [7:0] cur, oth, out_bus;
    logic       m_safe;
    int         d;

    // Board rows, row counter r (0..8) and check counter j.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) board[i] <= 8'h80;
            r <= 0;
            j <= 0;
        end else begin
            if (shift_right && r < 8) board[r[2:0]] <= {board[r[2:0]][0], board[r[2:0]][7:1]};
            if (counter_reset)   r <= 0;
            else if (count_up)   r <= r + 1;
            else if (count_down) r <= r - 1;
            if (load_counter)    j <= r - 1;
            else if (count)      j <= j - 1;
        end
    end

    // Stub: pretends to be on row 0 once the first check has been started.
    always @(posedge clk) begin
        if (!stub_mode)        stub_row0 <= 1'b0;
        else if (load_counter) stub_row0 <= 1'b1;
    end

    always_comb begin
        cur    = (r >= 0 && r < 8) ? board[r[2:0]] : 8'h00;
        oth    = (j >= 0 && j < 8) ? board[j[2:0]] : 8'h00;
        d      = r - j;
        m_safe = ((cur & (oth | (oth >> d) | (oth << d))) == 8'h00);
    end

    assign cout                    = stub_mode ? 1'b0      : (r == 8);
    assign last_queen_counter_zero = stub_mode ? stub_row0 : (r == 0);
    assign last_cell               = stub_mode ? 1'b1      : cur[0];
    assign safe                    = stub_mode ? 1'b0      : m_safe;
    assign down_counter_zero       = stub_mode ? 1'b0      : (j == 0);
    assign out_bus                 = enable_output ? cur : 8'h00;

    // ---------------- scoreboard / bookkeeping ----------------
    typedef struct packed {
        logic [2:0] row;
        logic [7:0] bus;
    } beat_t;

    beat_t      sb[$];
    logic [7:0] golden [8];
    int         total = 0;
    int         bad   = 0;
    int         beats = 0;
    int         stalls = 0;
    int         stub_cd = 0;
    bit         in_search = 0;
    bit         seen_load = 0;
    int         scyc = 0;
    int         scyc_last = 0;
    bit         stall_en = 0;
    int         stall_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample/score at the falling edge, then drive out_ready just after the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (!reset) begin
            in_search = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() > 0) begin
                    e = sb[0];
                    check("row", 32'(out_row), 32'(e.row));
                    check("bus", 32'(out_bus), 32'(e.bus));
                    if (out_ready) void'(sb.pop_front());
                end
                if (out_ready) beats++;
                else           stalls++;
            end
            if (counter_reset) begin
                if (!in_search) begin
                    in_search = 1;
                    scyc      = 0;
                end else begin
                    in_search = 0;
                    scyc_last = scyc;
                end
            end else if (in_search) begin
                scyc++;
            end
            if (load_counter) seen_load = 1;
            if (stub_mode && count_down) stub_cd++;
        end
        @(posedge clk);
        #1;
        if (stall_en && out_valid && out_row == 3'd3 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic check_search_cycles(input string tag);
        int exp;
`ifdef SEARCH_CYCLE_COUNT_EN
        exp = (scyc_last > 65535) ? 65535 : scyc_last;
        check({tag, "_nz"}, 32'(search_cycles != '0), 32'd1);
`else
        exp = 0;
`endif
        check(tag, 32'(search_cycles), 32'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic run_full(input bit stall);
        int b0, s0, n;
        for (int i = 0; i < 8; i++) sb.push_back(beat_t'{row: 3'(i), bus: golden[i]});
        b0         = beats;
        s0         = stalls;
        stall_en   = stall;
        stall_left = 3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (!done && !fail && n < 40000) begin
            tick();
            n++;
        end
        check("run_done", 32'(done), 32'd1);
        check("run_fail", 32'(fail), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        check("run_beats", 32'(beats - b0), 32'd8);
        check("run_stalls", 32'(stalls - s0), stall ? 32'd3 : 32'd0);
        check("sb_left", 32'(sb.size()), 32'd0);
        check_search_cycles("search_cycles");
        sb.delete();
        stall_en = 0;
    endtask

    initial begin
        int n, b0;
        golden    = '{8'h80, 8'h08, 8'h01, 8'h04, 8'h20, 8'h02, 8'h40, 8'h10};
        stub_mode = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        reset     = 1'b0;

        // Reset held two cycles with start high.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_row", 32'(out_row), 32'd0);
        check("rst_strobes", 32'({enable_output, shift_right, counter_reset, count_up,
                                   count_down, count, load_counter}), 32'd0);
        check("rst_cycles", 32'(search_cycles), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();

        // Full search, consumer always ready.
        run_full(1'b0);

        // A second start while done must be ignored.
        b0    = beats;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("done_held", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_beats", 32'(beats - b0), 32'd0);
        check_search_cycles("done_cycles");

        // Same search with a three-cycle stall on row 3.
        do_reset();
        run_full(1'b1);

        // Abort from CHECK via reset, then the board must come out identically.
        do_reset();
        seen_load = 0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (!seen_load && n < 100) begin
            tick();
            n++;
        end
        check("abort_reached_check", 32'(seen_load), 32'd1);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_strobes", 32'({enable_output, shift_right, counter_reset, count_up,
                                     count_down, count, load_counter}), 32'd0);
        reset = 1'b1;
        tick();
        run_full(1'b0);

        // Stub datapath: conflict on row 0 at the last column must fail without a count_down.
        reset     = 1'b0;
        tick();
        stub_mode = 1'b1;
        reset     = 1'b1;
        tick();
        b0    = beats;
        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (!fail && n < 50) begin
            tick();
            n++;
        end
        check("stub_cycles", 32'(n), 32'd4);
        check("stub_fail", 32'(fail), 32'd1);
        check("stub_done", 32'(done), 32'd0);
        check("stub_busy", 32'(busy), 32'd0);
        check("stub_count_down", 32'(stub_cd), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("stub_fail_held", 32'(fail), 32'd1);
        check("stub_busy_held", 32'(busy), 32'd0);
        check("stub_beats", 32'(beats - b0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
